// File: rtl/oled_pkg.sv
// oled_pkg: shared constants and types for the OLED SPI path.
//   OLED_WORD_W          serializer word width, {D/Cb, byte}
//   arb_state_t          arbiter FSM states
//   OLED_CMD_WRITE_RAM   controller "write RAM" command byte
//   OLED_CMD_DISPLAY_ON  controller "display on" command byte
package oled_pkg;

    localparam int unsigned OLED_WORD_W = 9;

    localparam logic [7:0] OLED_CMD_WRITE_RAM  = 8'h5C;
    localparam logic [7:0] OLED_CMD_DISPLAY_ON = 8'hAF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/oled_arb_pick.sv
// oled_arb_pick: combinational winner select for the OLED SPI arbiter.
//   valid0, valid1  requester valids
//   last_owner      (OLED_ARB_RR_EN only) 1 = requester 1 was granted most recently
//   pick            one-hot winner, 2'b00 when neither is valid
// Macro OLED_ARB_RR_EN: defined selects round-robin on ties,
// undefined gives requester 0 fixed priority.
module oled_arb_pick (
    input  logic       valid0,
    input  logic       valid1,
`ifdef OLED_ARB_RR_EN
    input  logic       last_owner,
`endif
    output logic [1:0] pick
);

    always_comb begin
        pick = '0;
        if (valid0 && valid1) begin
`ifdef OLED_ARB_RR_EN
            // The requester not granted most recently wins the tie.
            pick = last_owner ? 2'b01 : 2'b10;
`else
            pick = 2'b01;
`endif
        end else if (valid0) begin
            pick = 2'b01;
        end else if (valid1) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter: shares one OLED SPI byte serializer between a command
// sequencer (requester 0) and a pixel streamer (requester 1). A grant is
// locked for a whole burst (until a word flagged last completes) and is
// forcibly released if the owner leaves valid low for IDLE_TIMEOUT cycles.
// Ports:
//   CLK, RSTb                      clock, synchronous active-low reset
//   reqN_valid/dat/last            request word (held until reqN_ack)
//   reqN_ack, reqN_done            1-cycle accept / completion pulses
//   ser_go, ser_dat, ser_done      serializer handshake
//   grant, busy                    one-hot owner, grant != 0
//   burst_count                    words completed in current burst, saturating
//   timeout_err                    1-cycle pulse on timeout release
// Macro OLED_ARB_RR_EN: round-robin tie break (default: fixed priority).
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 1023,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic                   req0_valid,
    input  logic [OLED_WORD_W-1:0] req0_dat,
    input  logic                   req0_last,
    output logic                   req0_ack,
    output logic                   req0_done,
    input  logic                   req1_valid,
    input  logic [OLED_WORD_W-1:0] req1_dat,
    input  logic                   req1_last,
    output logic                   req1_ack,
    output logic                   req1_done,
    output logic                   ser_go,
    output logic [OLED_WORD_W-1:0] ser_dat,
    input  logic                   ser_done,
    output logic [1:0]             grant,
    output logic                   busy,
    output logic [CNT_W-1:0]       burst_count,
    output logic                   timeout_err
);

    localparam int unsigned    TO_W    = $clog2(IDLE_TIMEOUT + 1);
    // Counter value in the last idle HOLD cycle before release.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);

    arb_state_t       state;
    logic             last_word;
    logic [TO_W-1:0]  idle_cnt;
    logic [1:0]       pick;
    logic             owner_valid;
    logic [OLED_WORD_W-1:0] owner_dat;
    logic             owner_last;

`ifdef OLED_ARB_RR_EN
    logic             last_owner;
`endif

    oled_arb_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
`ifdef OLED_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .pick       (pick)
    );

    always_comb begin
        owner_valid = grant[1] ? req1_valid : req0_valid;
        owner_dat   = grant[1] ? req1_dat   : req0_dat;
        owner_last  = grant[1] ? req1_last  : req0_last;
    end

    assign busy = |grant;

    // ser_go/ack are set on the edge that enters ISSUE so they are high
    // exactly during the ISSUE cycle, one cycle after valid is sampled.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state       <= IDLE;
            grant       <= '0;
            last_word   <= 1'b0;
            idle_cnt    <= '0;
            ser_go      <= 1'b0;
            ser_dat     <= '0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            burst_count <= '0;
            timeout_err <= 1'b0;
`ifdef OLED_ARB_RR_EN
            last_owner  <= 1'b1;
`endif
        end else begin
            ser_go      <= 1'b0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        grant     <= pick;
                        ser_dat   <= pick[1] ? req1_dat  : req0_dat;
                        last_word <= pick[1] ? req1_last : req0_last;
                        ser_go    <= 1'b1;
                        req0_ack  <= pick[0];
                        req1_ack  <= pick[1];
`ifdef OLED_ARB_RR_EN
                        last_owner <= pick[1];
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (ser_done) begin
                        req0_done <= grant[0];
                        req1_done <= grant[1];
                        if (last_word) begin
                            grant       <= '0;
                            burst_count <= '0;
                            state       <= IDLE;
                        end else begin
                            if (burst_count != '1) begin
                                burst_count <= burst_count + CNT_W'(1);
                            end
                            idle_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (owner_valid) begin
                        ser_dat   <= owner_dat;
                        last_word <= owner_last;
                        ser_go    <= 1'b1;
                        req0_ack  <= grant[0];
                        req1_ack  <= grant[1];
                        idle_cnt  <= '0;
                        state     <= ISSUE;
                    end else if (idle_cnt == TO_LAST) begin
                        // A timed-out burst is over, so its count restarts too.
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        burst_count <= '0;
                        idle_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// tb_oled_spi_arbiter: scoreboard bench for oled_spi_arbiter with a
// behavioural serializer. Built with IDLE_TIMEOUT=8, CNT_W=2.
// Honours OLED_ARB_RR_EN for the tie-break expectations.
module tb_oled_spi_arbiter;
    import oled_pkg::*;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 2;

    logic                   clk;
    logic                   rstb;
    logic                   req0_valid, req0_last, req0_ack, req0_done;
    logic [OLED_WORD_W-1:0] req0_dat;
    logic                   req1_valid, req1_last, req1_ack, req1_done;
    logic [OLED_WORD_W-1:0] req1_dat;
    logic                   ser_go, ser_done;
    logic [OLED_WORD_W-1:0] ser_dat;
    logic [1:0]             grant;
    logic                   busy;
    logic [CW-1:0]          burst_count;
    logic                   timeout_err;

    oled_spi_arbiter #(.IDLE_TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(clk), .RSTb(rstb),
        .req0_valid(req0_valid), .req0_dat(req0_dat), .req0_last(req0_last),
        .req0_ack(req0_ack), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_dat(req1_dat), .req1_last(req1_last),
        .req1_ack(req1_ack), .req1_done(req1_done),
        .ser_go(ser_go), .ser_dat(ser_dat), .ser_done(ser_done),
        .grant(grant), .busy(busy), .burst_count(burst_count),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] dat;
        logic [1:0] grant;
        logic [1:0] done;
        logic [1:0] cnt;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  ser_lat = 4;
    bit  model_idle = 1'b1;
    bit  burst1_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic sb_t mk(input logic [8:0] d, input logic [1:0] g,
                               input logic [1:0] dn, input logic [1:0] c);
        sb_t e;
        e.dat = d; e.grant = g; e.done = dn; e.cnt = c;
        return e;
    endfunction

    // Behavioural serializer: pops the expected word on each ser_go,
    // answers with ser_done after ser_lat cycles, then checks the done pulse.
    initial begin
        sb_t e;
        ser_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ser_go) begin
                model_idle = 1'b0;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ser_dat", ser_dat, e.dat);
                    chk("go_grant", grant, e.grant);
                    chk("ack", {req1_ack, req0_ack}, e.grant);
                    chk("busy", busy, 1);
                    repeat (ser_lat) @(negedge clk);
                    if (e.done != 2'b00) chk("ser_dat_hold", ser_dat, e.dat);
                    ser_done = 1'b1;
                    @(negedge clk);
                    ser_done = 1'b0;
                    chk("done", {req1_done, req0_done}, e.done);
                    chk("burst_count", burst_count, e.cnt);
                end
                model_idle = 1'b1;
            end
        end
    end

    task automatic send(input int id, input logic [8:0] d, input logic l,
                        input int exp_lat, input bit wait_done);
        int n;
        bit seen;
        if (id == 0) begin req0_valid = 1'b1; req0_dat = d; req0_last = l; end
        else         begin req1_valid = 1'b1; req1_dat = d; req1_last = l; end
        seen = 1'b0; n = 0;
        while (!seen && n < 200) begin
            @(negedge clk); n++;
            seen = (id == 0) ? req0_ack : req1_ack;
        end
        chk("ack_seen", seen, 1);
        if (exp_lat > 0) chk("ack_latency", n, exp_lat);
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (wait_done) begin
            seen = 1'b0; n = 0;
            while (!seen && n < 200) begin
                @(negedge clk); n++;
                seen = (id == 0) ? req0_done : req1_done;
            end
            chk("done_seen", seen, 1);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && model_idle && sb.size() == 0;
        end
        chk("idle_reached", ok, 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ser_go"}, ser_go, 0);
        chk({tag, "_ser_dat"}, ser_dat, 0);
        chk({tag, "_acks"}, {req1_ack, req0_ack}, 0);
        chk({tag, "_dones"}, {req1_done, req0_done}, 0);
        chk({tag, "_burst_count"}, burst_count, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        logic [1:0] tie_exp [2];
        logic [8:0] w0, w1;
        bit seen;

        rstb = 1'b0;
        req0_valid = 1'b0; req0_dat = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_dat = '0; req1_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rstb = 1'b1;
        @(negedge clk);

        // Tie in IDLE, twice; the loser withdraws once the winner is acked.
        w0 = {1'b0, OLED_CMD_DISPLAY_ON};
        w1 = 9'h111;
        tie_exp[0] = 2'b01;
`ifdef OLED_ARB_RR_EN
        tie_exp[1] = 2'b10;
`else
        tie_exp[1] = 2'b01;
`endif
        for (int r = 0; r < 2; r++) begin
            sb.push_back(mk(tie_exp[r][1] ? w1 : w0, tie_exp[r], tie_exp[r], 2'd0));
            req0_valid = 1'b1; req0_dat = w0; req0_last = 1'b1;
            req1_valid = 1'b1; req1_dat = w1; req1_last = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = req0_ack | req1_ack;
            end
            chk("tie_ack_seen", seen, 1);
            chk("tie_winner", {req1_ack, req0_ack}, tie_exp[r]);
            req0_valid = 1'b0; req1_valid = 1'b0;
            wait_idle();
        end

        // Single command.
        sb.push_back(mk(9'h0AF, 2'b01, 2'b01, 2'd0));
        send(0, 9'h0AF, 1'b1, 1, 1'b1);
        chk("single_grant", grant, 0);
        chk("single_count", burst_count, 0);
        wait_idle();

        // Burst lock: req0 arrives mid-burst and must wait for req1's last word.
        sb.push_back(mk({1'b0, OLED_CMD_WRITE_RAM}, 2'b10, 2'b10, 2'd1));
        sb.push_back(mk(9'h1AB, 2'b10, 2'b10, 2'd2));
        sb.push_back(mk(9'h1CD, 2'b10, 2'b10, 2'd0));
        sb.push_back(mk(9'h0A4, 2'b01, 2'b01, 2'd0));
        burst1_done = 1'b0;
        fork
            begin
                send(1, {1'b0, OLED_CMD_WRITE_RAM}, 1'b0, 1, 1'b1);
                send(1, 9'h1AB, 1'b0, 1, 1'b1);
                send(1, 9'h1CD, 1'b1, 1, 1'b1);
                burst1_done = 1'b1;
            end
            begin
                repeat (3) @(negedge clk);
                req0_valid = 1'b1; req0_dat = 9'h0A4; req0_last = 1'b1;
                seen = 1'b0;
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(negedge clk);
                    seen = req0_ack;
                end
                chk("lock_ack_seen", seen, 1);
                chk("lock_ack_after_burst", burst1_done, 1);
                req0_valid = 1'b0;
            end
        join
        wait_idle();

        // Timeout: req1 abandons its burst, a pending req0 is served afterwards.
        sb.push_back(mk({1'b0, OLED_CMD_WRITE_RAM}, 2'b10, 2'b10, 2'd1));
        sb.push_back(mk(9'h0A4, 2'b01, 2'b01, 2'd0));
        fork
            begin
                send(1, {1'b0, OLED_CMD_WRITE_RAM}, 1'b0, 1, 1'b1);
                for (int k = 1; k <= 8; k++) begin
                    @(negedge clk);
                    if (k == 7) begin
                        chk("to_not_early", timeout_err, 0);
                        chk("to_grant_held", grant, 2'b10);
                    end
                    if (k == 8) begin
                        chk("timeout_err", timeout_err, 1);
                        chk("to_grant_clr", grant, 0);
                    end
                end
            end
            begin
                repeat (2) @(negedge clk);
                send(0, 9'h0A4, 1'b1, 0, 1'b1);
            end
        join
        wait_idle();

        // Reset while the serializer is mid-word.
        ser_lat = 20;
        sb.push_back(mk(9'h0AF, 2'b01, 2'b00, 2'd0));
        send(0, 9'h0AF, 1'b1, 1, 1'b0);
        repeat (3) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        check_reset_state("midrst");
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = model_idle;
        end
        chk("midrst_ser_returned", seen, 1);
        ser_lat = 4;
        wait_idle();

        // Saturation: five-word burst with a 2-bit counter, then timeout.
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(9'h100 + 9'(i), 2'b01, 2'b01, (i < 3) ? 2'(i + 1) : 2'd3));
        end
        for (int i = 0; i < 5; i++) begin
            send(0, 9'h100 + 9'(i), 1'b0, 1, 1'b1);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = timeout_err;
        end
        chk("sat_timeout", seen, 1);
        wait_idle();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
